mb_loop_ctrl: RTL and testbench



---
 rtl/mb_loop_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_mb_loop_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mb_loop_ctrl.sv
// Mandelbulb loop issue/recirculation controller: merges new rays with returning
// messages, retires finished ones into a FWFT exit FIFO. Optional MB_LOOP_STATS_EN adds counters.
package fixedpoint;
  typedef logic signed [15:0] fix_t;
  localparam fix_t FIX_ONE = 16'sh1000;  // Q4.12
  typedef struct packed {
    logic [15:0] pixel_id;
    fix_t        pos_x;
    fix_t        pos_y;
    fix_t        pos_z;
    fix_t        x_iter;
    fix_t        y_iter;
    fix_t        z_iter;
    fix_t        dr;
    fix_t        r;
    logic [7:0]  steps;
    logic        threshold;
  } message;
endpackage

// Handshake: in_valid/in_ready transfer when both high in a cycle; done_valid/done_ready
// pop the FIFO head when both high; loop_valid and out_valid have no backpressure.
module mb_loop_ctrl
  import fixedpoint::*;
#(
  parameter int MAX_STEPS  = 8,
  parameter int MAX_TOKENS = 64,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  message                           data_in,
  input  logic                             loop_valid,
  input  message                           loop_data,
  output logic                             out_valid,
  output message                           data_out,
  output logic                             done_valid,
  input  logic                             done_ready,
  output message                           done_data,
  input  logic                             flush,
  output logic                             flush_done,
  output logic [1:0]                       dbg_state,
  output logic [$clog2(MAX_TOKENS+1)-1:0]  dbg_tokens
`ifdef MB_LOOP_STATS_EN
  ,
  output logic [31:0]                      stat_injected,
  output logic [31:0]                      stat_retired,
  output logic [31:0]                      stat_stall
`endif
);
  localparam int TW = $clog2(MAX_TOKENS + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [TW-1:0] TOK_MAX    = TW'(MAX_TOKENS);
  localparam logic [PW-1:0] PTR_LAST   = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL   = CW'(FIFO_DEPTH);
  localparam logic [7:0]    STEP_LIMIT = 8'(MAX_STEPS);

  generate
    if (FIFO_DEPTH < MAX_TOKENS) begin : g_depth_chk
      $error("mb_loop_ctrl: FIFO_DEPTH must be >= MAX_TOKENS");
    end
  endgenerate

  typedef enum logic [1:0] {S_RUN = 2'd0, S_DRAIN = 2'd1, S_DONE = 2'd2, S_IDLE = 2'd3} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tokens_q, tokens_d;
  logic          out_valid_q, out_valid_d;
  message        data_out_q, data_out_d;
  message        mem_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          loop_exit, loop_cont, accept;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  message        injected;

  assign loop_exit  = loop_data.threshold || (loop_data.steps >= STEP_LIMIT);
  assign loop_cont  = loop_valid && !loop_exit;
  assign fifo_push  = loop_valid && loop_exit;
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_FULL);
  assign fifo_pop   = !fifo_empty && done_ready;
  assign accept     = in_valid && in_ready;

  // Fresh ray: iteration state starts at the ray position with unit derivative.
  always_comb begin
    injected           = data_in;
    injected.steps     = '0;
    injected.threshold = 1'b0;
    injected.dr        = FIX_ONE;
    injected.x_iter    = data_in.pos_x;
    injected.y_iter    = data_in.pos_y;
    injected.z_iter    = data_in.pos_z;
    injected.r         = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (flush) state_d = S_DRAIN;
      S_DRAIN: begin
        if (!flush)               state_d = S_RUN;
        else if (tokens_q == '0)  state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      S_IDLE:  if (!flush) state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  // in_ready is held low during reset so nothing is taken while rst is high.
  always_comb begin
    in_ready   = 1'b0;
    flush_done = 1'b0;
    case (state_q)
      S_RUN:   in_ready = !rst && !loop_cont && (tokens_q < TOK_MAX);
      S_DONE:  flush_done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    out_valid_d = loop_cont || accept;
    data_out_d  = data_out_q;
    if (loop_cont)   data_out_d = loop_data;
    else if (accept) data_out_d = injected;

    tokens_d = tokens_q;
    case ({accept, fifo_pop})
      2'b10:   tokens_d = tokens_q + TW'(1);
      2'b01:   tokens_d = tokens_q - TW'(1);
      default: ;
    endcase

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (fifo_push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
    if (fifo_pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
    if (fifo_push && !fifo_pop)      count_d = count_q + CW'(1);
    else if (fifo_pop && !fifo_push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      tokens_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
      tokens_q    <= tokens_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (fifo_push) mem_q[wr_ptr_q] <= loop_data;
  end

  overflow_chk: assert property (@(posedge clk) disable iff (rst)
    !(fifo_push && fifo_full && !fifo_pop));

  assign out_valid  = out_valid_q;
  assign data_out   = data_out_q;
  assign done_valid = !fifo_empty;
  assign done_data  = mem_q[rd_ptr_q];
  assign dbg_state  = state_q;
  assign dbg_tokens = tokens_q;

`ifdef MB_LOOP_STATS_EN
  logic [31:0] stat_inj_q, stat_inj_d, stat_ret_q, stat_ret_d, stat_stall_q, stat_stall_d;

  always_comb begin
    stat_inj_d   = stat_inj_q + 32'(accept);
    stat_ret_d   = stat_ret_q + 32'(fifo_push);
    stat_stall_d = stat_stall_q + 32'(in_valid && !in_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_inj_q   <= '0;
      stat_ret_q   <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_inj_q   <= stat_inj_d;
      stat_ret_q   <= stat_ret_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_injected = stat_inj_q;
  assign stat_retired  = stat_ret_q;
  assign stat_stall    = stat_stall_q;
`endif
endmodule

// File: tb/tb_mb_loop_ctrl.sv
// Bench for mb_loop_ctrl: emulated iteration pipeline feeding loop_*, transaction-level
// reference model checked every cycle, plus directed literal checks.
module tb_mb_loop_ctrl;
  import fixedpoint::*;

  localparam int MAX_STEPS  = 8;
  localparam int MAX_TOKENS = 64;
  localparam int PIPE_LAT   = 3;
  localparam int MW         = $bits(message);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0, in_ready;
  message     data_in = '0;
  logic       loop_valid = 1'b0;
  message     loop_data = '0;
  logic       out_valid;
  message     data_out;
  logic       done_valid, done_ready = 1'b0;
  message     done_data;
  logic       flush = 1'b0, flush_done;
  logic [1:0] dbg_state;
  logic [6:0] dbg_tokens;
`ifdef MB_LOOP_STATS_EN
  logic [31:0] stat_injected, stat_retired, stat_stall;
`endif

  always #5 clk = ~clk;

  mb_loop_ctrl #(.MAX_STEPS(MAX_STEPS), .MAX_TOKENS(MAX_TOKENS), .FIFO_DEPTH(64)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .loop_valid(loop_valid), .loop_data(loop_data),
    .out_valid(out_valid), .data_out(data_out),
    .done_valid(done_valid), .done_ready(done_ready), .done_data(done_data),
    .flush(flush), .flush_done(flush_done),
    .dbg_state(dbg_state), .dbg_tokens(dbg_tokens)
`ifdef MB_LOOP_STATS_EN
    , .stat_injected(stat_injected), .stat_retired(stat_retired), .stat_stall(stat_stall)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  function automatic void check(string name, logic [MW-1:0] act, logic [MW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic message init_msg(message d);
    message m;
    m = d;
    m.steps = 8'd0;
    m.threshold = 1'b0;
    m.dr = 16'sh1000;
    m.x_iter = d.pos_x;
    m.y_iter = d.pos_y;
    m.z_iter = d.pos_z;
    m.r = '0;
    return m;
  endfunction

  function automatic message rand_msg();
    logic [159:0] raw;
    raw = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return raw[MW-1:0];
  endfunction

  // ---------------- emulated iteration pipeline ----------------
  int     thr_mode = 0;  // 0: only step limit retires, 1: always retire, 2: random threshold
  bit     pipe_v [PIPE_LAT];
  message pipe_d [PIPE_LAT];

  function automatic message advance(message m);
    message n;
    n = m;
    n.steps = m.steps + 8'd1;
    if (thr_mode == 1)      n.threshold = 1'b1;
    else if (thr_mode == 2) n.threshold = ($urandom_range(0, 9) == 0);
    n.x_iter = m.x_iter + 16'($urandom_range(0, 255));
    n.r = 16'($urandom);
    return n;
  endfunction

  always @(posedge clk) begin
    #1;
    if (rst) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        pipe_v[i] = 1'b0;
        pipe_d[i] = '0;
      end
    end else begin
      for (int i = PIPE_LAT - 1; i > 0; i--) begin
        pipe_v[i] = pipe_v[i-1];
        pipe_d[i] = pipe_d[i-1];
      end
      pipe_v[0] = out_valid;
      pipe_d[0] = advance(data_out);
    end
    loop_valid = pipe_v[PIPE_LAT-1];
    loop_data  = pipe_d[PIPE_LAT-1];
  end

  // ---------------- reference model + compare ----------------
  typedef enum {M_RUN, M_DRAIN, M_DONE, M_IDLE} mstate_t;
  mstate_t       m_state = M_RUN;
  bit            m_out_valid = 1'b0;
  message        m_data_out = '0;
  logic [MW-1:0] exp_q[$];
  int            m_tokens = 0;
  int unsigned   m_inj = 0, m_ret = 0, m_stall = 0;

  always @(negedge clk) begin : model
    bit exit_now, exp_ready, acc, pop, push;
    if (rst) begin
      m_state = M_RUN; m_out_valid = 1'b0; m_data_out = '0; exp_q.delete();
      m_tokens = 0; m_inj = 0; m_ret = 0; m_stall = 0;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_done_valid", done_valid, 1'b0);
      check("rst_flush_done", flush_done, 1'b0);
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_tokens", dbg_tokens, 0);
    end else begin
      exit_now  = loop_data.threshold || (int'(loop_data.steps) >= MAX_STEPS);
      exp_ready = (m_state == M_RUN) && !(loop_valid && !exit_now) && (m_tokens < MAX_TOKENS);
      check("out_valid", out_valid, m_out_valid);
      if (m_out_valid) check("data_out", data_out, m_data_out);
      check("done_valid", done_valid, exp_q.size() > 0);
      if (exp_q.size() > 0) check("done_data", done_data, exp_q[0]);
      check("flush_done", flush_done, m_state == M_DONE);
      check("in_ready", in_ready, exp_ready);
      check("tokens", dbg_tokens, m_tokens);
`ifdef MB_LOOP_STATS_EN
      check("stat_injected", stat_injected, m_inj);
      check("stat_retired", stat_retired, m_ret);
      check("stat_stall", stat_stall, m_stall);
`endif
      acc  = in_valid && exp_ready;
      pop  = (exp_q.size() > 0) && done_ready;
      push = loop_valid && exit_now;
      m_out_valid = (loop_valid && !exit_now) || acc;
      if (loop_valid && !exit_now) m_data_out = loop_data;
      else if (acc)                m_data_out = init_msg(data_in);
      if (pop)  void'(exp_q.pop_front());
      if (push) exp_q.push_back(loop_data);
      case (m_state)
        M_RUN:   if (flush) m_state = M_DRAIN;
        M_DRAIN: if (!flush) m_state = M_RUN; else if (m_tokens == 0) m_state = M_DONE;
        M_DONE:  m_state = M_IDLE;
        M_IDLE:  if (!flush) m_state = M_RUN;
        default: m_state = M_RUN;
      endcase
      m_tokens = m_tokens + int'(acc) - int'(pop);
      m_inj += acc;
      m_ret += push;
      m_stall += (in_valid && !exp_ready);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tokens_zero(string name);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b0;
    done_ready = 1'b1;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (dbg_tokens == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, ok, 1'b1);
    step();
  endtask

  task automatic inject_n(int n);
    int acc;
    acc = 0;
    in_valid = 1'b1;
    data_in = rand_msg();
    for (int g = 0; g < 100 && acc < n; g++) begin
      @(negedge clk);
      if (in_ready) acc++;
      step();
      data_in = rand_msg();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    message m, ld, sent;
    int pulses, leaks;
    bit seen;

    // reset
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("lit_rst_out_valid", out_valid, 1'b0);
    check("lit_rst_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;

    // single injection: override fields, 1-cycle latency
    m = rand_msg();
    m.pos_x = 16'sh0800; m.steps = 8'd7; m.threshold = 1'b1; m.dr = 16'sh7fff;
    in_valid = 1'b1; data_in = m;
    @(negedge clk);
    check("lit_t1_in_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("lit_t1_out_valid", out_valid, 1'b1);
    check("lit_t1_steps", data_out.steps, 8'd0);
    check("lit_t1_threshold", data_out.threshold, 1'b0);
    check("lit_t1_x_iter", data_out.x_iter, 16'h0800);
    check("lit_t1_dr", data_out.dr, 16'h1000);
    check("lit_t1_tokens", dbg_tokens, 7'd1);

    // loop priority: returning message blocks injection, then injection proceeds
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = pipe_v[PIPE_LAT-2];
    end
    check("t2_loop_return", seen, 1'b1);
    step();
    in_valid = 1'b1; sent = rand_msg(); data_in = sent;
    @(negedge clk);
    check("lit_t2_blocked", in_ready, 1'b0);
    ld = loop_data;
    step();
    @(negedge clk);
    check("lit_t2_loop_out", data_out, ld);
    check("lit_t2_accept", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("lit_t2_inj_out", data_out, init_msg(sent));

    // randomized traffic with occasional flush toggles
    thr_mode = 2;
    for (int c = 0; c < 3000; c++) begin
      step();
      in_valid = $urandom_range(0, 1);
      data_in = rand_msg();
      done_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 59) == 0) flush = ~flush;
    end
    step();
    flush = 1'b0;
    wait_tokens_zero("drain_random");
    repeat (3) step();

    // credit limit: 64 tokens held with no pops
    thr_mode = 1;
    done_ready = 1'b0;
    in_valid = 1'b1;
    for (int c = 0; c < 120; c++) begin
      data_in = rand_msg();
      step();
    end
    @(negedge clk);
    check("lit_full_tokens", dbg_tokens, 7'd64);
    check("lit_full_in_ready", in_ready, 1'b0);
    check("lit_full_done_valid", done_valid, 1'b1);
    step();
    done_ready = 1'b1;
    @(negedge clk);
    check("lit_full_still_blocked", in_ready, 1'b0);
    step();
    done_ready = 1'b0;
    @(negedge clk);
    check("lit_full_reopen", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    wait_tokens_zero("drain_full");

    // flush with 5 tokens outstanding
    thr_mode = 0;
    done_ready = 1'b0;
    inject_n(5);
    flush = 1'b1;
    step();
    in_valid = 1'b1;
    @(negedge clk);
    check("lit_flush_block", in_ready, 1'b0);
    check("lit_flush_tokens", dbg_tokens, 7'd5);
    step();
    done_ready = 1'b1;
    pulses = 0; leaks = 0;
    for (int c = 0; c < 250; c++) begin
      @(negedge clk);
      if (flush_done) pulses++;
      if (in_ready) leaks++;
    end
    check("lit_flush_pulse_count", pulses, 1);
    check("lit_flush_no_accept", leaks, 0);
    step();
    flush = 1'b0;
    step();
    @(negedge clk);
    check("lit_flush_release", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    wait_tokens_zero("drain_flush");

    // asynchronous reset with FIFO holding 3 retired messages
    thr_mode = 1;
    done_ready = 1'b0;
    inject_n(3);
    repeat (10) step();
    @(negedge clk);
    check("lit_rst3_done_valid", done_valid, 1'b1);
    check("lit_rst3_tokens", dbg_tokens, 7'd3);
    #2 rst = 1'b1;
    #1;
    check("lit_async_done_valid", done_valid, 1'b0);
    check("lit_async_out_valid", out_valid, 1'b0);
    check("lit_async_tokens", dbg_tokens, 7'd0);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
